// File: rtl/mem_access_stage_if.sv
// Bundles the EX/MEM-side request and MEM/WB-side result signals of the MEM stage.
// misalign_o exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_access_stage_if;
    logic        valid_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        MemtoReg_i;
    logic        Regwrite_i;
    logic [31:0] ALU_result_i;
    logic [31:0] Write_data_i;
    logic [4:0]  Reg_addr_i;
    logic        flush_i;
    logic        stall_o;
    logic        MemtoReg_o;
    logic        Regwrite_o;
    logic [31:0] ALU_result_o;
    logic [31:0] Mem_data_o;
    logic [4:0]  Reg_addr_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  misalign_o,
`endif
        output valid_i, MemRead_i, MemWrite_i, MemtoReg_i, Regwrite_i,
        output ALU_result_i, Write_data_i, Reg_addr_i, flush_i,
        input  stall_o, MemtoReg_o, Regwrite_o, ALU_result_o, Mem_data_o, Reg_addr_o
    );

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output misalign_o,
`endif
        input  valid_i, MemRead_i, MemWrite_i, MemtoReg_i, Regwrite_i,
        input  ALU_result_i, Write_data_i, Reg_addr_i, flush_i,
        output stall_o, MemtoReg_o, Regwrite_o, ALU_result_o, Mem_data_o, Reg_addr_o
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle load/store against an internal word-addressed RAM.
// Optional alignment checking is enabled with the MEM_ALIGN_CHECK_EN macro.
module mem_access_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_stage_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // The accept cycle is the first stall cycle, so BUSY lasts LATENCY-1 cycles.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam bit DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;
    logic              m2r_q, m2r_d;
    logic              rw_q, rw_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we, mem_re;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_wdata;

    logic              stall_c, m2r_c, rw_c, misalign_c;
    logic [31:0]       alu_c, mdata_c;
    logic [4:0]        rd_c;
    logic              accept, aligned_in, aligned_lat;

`ifdef MEM_ALIGN_CHECK_EN
    assign aligned_in  = (bus.ALU_result_i[1:0] == 2'b00);
    assign aligned_lat = (alu_q[1:0] == 2'b00);
`else
    assign aligned_in  = 1'b1;
    assign aligned_lat = 1'b1;
`endif

    assign accept = bus.valid_i && (bus.MemRead_i || bus.MemWrite_i) && !bus.flush_i;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        alu_d      = alu_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_idx    = alu_q[IDX_W+1:2];
        mem_wdata  = wdata_q;
        stall_c    = 1'b0;
        m2r_c      = 1'b0;
        rw_c       = 1'b0;
        alu_c      = alu_q;
        rd_c       = rd_q;
        mdata_c    = 32'h0;
        misalign_c = 1'b0;
        case (state_q)
            IDLE: begin
                alu_c = bus.ALU_result_i;
                rd_c  = bus.Reg_addr_i;
                if (accept) begin
                    stall_c    = 1'b1;
                    is_store_d = bus.MemWrite_i;
                    is_load_d  = bus.MemRead_i && !bus.MemWrite_i;
                    m2r_d      = bus.MemtoReg_i;
                    rw_d       = bus.Regwrite_i;
                    alu_d      = bus.ALU_result_i;
                    wdata_d    = bus.Write_data_i;
                    rd_d       = bus.Reg_addr_i;
                    count_d    = CNT_INIT;
                    if (DIRECT) begin
                        mem_idx   = bus.ALU_result_i[IDX_W+1:2];
                        mem_wdata = bus.Write_data_i;
                        mem_we    = bus.MemWrite_i && aligned_in;
                        mem_re    = bus.MemRead_i && !bus.MemWrite_i;
                        state_d   = DONE;
                    end else begin
                        state_d   = BUSY;
                    end
                end else if (!bus.flush_i) begin
                    m2r_c = bus.MemtoReg_i;
                    rw_c  = bus.Regwrite_i;
                end
            end
            BUSY: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (count_q == '0) begin
                        mem_we  = is_store_q && aligned_lat;
                        mem_re  = is_load_q;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            DONE: begin
                m2r_c   = m2r_q;
                rw_c    = rw_q;
                mdata_c = is_load_q ? rdata_q : 32'h0;
                state_d = IDLE;
                if (!aligned_lat) begin
                    misalign_c = 1'b1;
                    if (is_load_q) begin
                        mdata_c = 32'h0;
                        rw_c    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata_d = mem_re ? mem[mem_idx] : rdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            alu_q      <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM contents survive reset; a write is blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_i) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_comb begin
        if (!rst_i) begin
            bus.stall_o      = 1'b0;
            bus.MemtoReg_o   = 1'b0;
            bus.Regwrite_o   = 1'b0;
            bus.ALU_result_o = 32'h0;
            bus.Mem_data_o   = 32'h0;
            bus.Reg_addr_o   = 5'h0;
        end else begin
            bus.stall_o      = stall_c;
            bus.MemtoReg_o   = m2r_c;
            bus.Regwrite_o   = rw_c;
            bus.ALU_result_o = alu_c;
            bus.Mem_data_o   = mdata_c;
            bus.Reg_addr_o   = rd_c;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign bus.misalign_o = rst_i & misalign_c;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_c;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (DEPTH=256, LATENCY=2); MEM_ALIGN_CHECK_EN adds the alignment test.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] ra);
        bus.valid_i      = v;
        bus.MemRead_i    = rd;
        bus.MemWrite_i   = wr;
        bus.MemtoReg_i   = rd;
        bus.Regwrite_i   = rd;
        bus.ALU_result_i = a;
        bus.Write_data_i = wd;
        bus.Reg_addr_i   = ra;
        bus.flush_i      = 1'b0;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    endtask

    // Runs one memory op from its accept cycle through DONE, recording what was observed.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] ra,
                          output logic [2:0] stall_seen, output logic [2:0] rw_seen,
                          output logic [31:0] data_seen, output logic m2r_seen);
        drive(1'b1, rd, wr, a, wd, ra);
        data_seen = 32'h0;
        m2r_seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            stall_seen[i] = bus.stall_o;
            rw_seen[i]    = bus.Regwrite_o;
            if (i == 2) begin
                data_seen = bus.Mem_data_o;
                m2r_seen  = bus.MemtoReg_o;
            end
            @(posedge clk);
            #1;
        end
        idle_in();
        $display("op %s addr=%h wdata=%h stall=%b rw=%b data=%h", rd ? "LD" : "ST", a, wd,
                 stall_seen, rw_seen, data_seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7);
        bus.MemtoReg_i = 1'b1;
        bus.Regwrite_i = 1'b1;
        #3;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.Regwrite_o !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", bus.Regwrite_o); end
        checks++; if (bus.MemtoReg_o !== 1'b0) begin errors++; $display("FAIL reset_m2r got=%b exp=0", bus.MemtoReg_o); end
        checks++; if (bus.ALU_result_o !== 32'h0) begin errors++; $display("FAIL reset_alu got=%h exp=0", bus.ALU_result_o); end
        checks++; if (bus.Mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_mdata got=%h exp=0", bus.Mem_data_o); end
        checks++; if (bus.Reg_addr_o !== 5'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", bus.Reg_addr_o); end
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (bus.misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign_o); end
`endif
        $display("reset held: outputs sampled");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7);
        bus.Regwrite_i = 1'b1;
        #1;
        checks++; if (bus.ALU_result_o !== 32'h1234) begin errors++; $display("FAIL pt_alu got=%h exp=00001234", bus.ALU_result_o); end
        checks++; if (bus.Reg_addr_o !== 5'd7) begin errors++; $display("FAIL pt_rd got=%0d exp=7", bus.Reg_addr_o); end
        checks++; if (bus.Regwrite_o !== 1'b1) begin errors++; $display("FAIL pt_rw got=%b exp=1", bus.Regwrite_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL pt_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.Mem_data_o !== 32'h0) begin errors++; $display("FAIL pt_mdata got=%h exp=0", bus.Mem_data_o); end
        $display("op ALU alu=%h rd=%0d rw=%b", bus.ALU_result_o, bus.Reg_addr_o, bus.Regwrite_o);
        @(posedge clk); #1;
        // MemRead without valid must not start an access
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3);
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL pt_invalid_stall got=%b exp=0", bus.stall_o); end
        @(posedge clk); #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL pt_invalid_stall2 got=%b exp=0", bus.stall_o); end
        $display("op NOP valid=0 stall=%b", bus.stall_o);
        idle_in();
    endtask

    task automatic test_store_load();
        logic [2:0] st, rw; logic [31:0] d; logic m;
        mem_op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 5'd0, st, rw, d, m);
        checks++; if (st !== 3'b011) begin errors++; $display("FAIL st_stall got=%b exp=011", st); end
        checks++; if (rw !== 3'b000) begin errors++; $display("FAIL st_rw got=%b exp=000", rw); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL st_mdata got=%h exp=0", d); end
        mem_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, st, rw, d, m);
        checks++; if (st !== 3'b011) begin errors++; $display("FAIL ld_stall got=%b exp=011", st); end
        checks++; if (rw !== 3'b100) begin errors++; $display("FAIL ld_rw got=%b exp=100", rw); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_mdata got=%h exp=deadbeef", d); end
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL ld_m2r got=%b exp=1", m); end
    endtask

    task automatic test_wrap();
        logic [2:0] st, rw; logic [31:0] d; logic m;
        mem_op(1'b0, 1'b1, 32'h400, 32'h11, 5'd0, st, rw, d, m);
        checks++; if (st !== 3'b011) begin errors++; $display("FAIL wrap_st_stall got=%b exp=011", st); end
        mem_op(1'b1, 1'b0, 32'h0, 32'h0, 5'd2, st, rw, d, m);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL wrap_ld_mdata got=%h exp=00000011", d); end
        // Read-and-write together behaves as a store
        mem_op(1'b1, 1'b1, 32'h4, 32'h22, 5'd2, st, rw, d, m);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rdwr_mdata got=%h exp=0", d); end
        mem_op(1'b1, 1'b0, 32'h4, 32'h0, 5'd2, st, rw, d, m);
        checks++; if (d !== 32'h22) begin errors++; $display("FAIL rdwr_ld_mdata got=%h exp=00000022", d); end
    endtask

    task automatic test_flush();
        logic [2:0] st, rw; logic [31:0] d; logic m;
        mem_op(1'b0, 1'b1, 32'h80, 32'hAAAA5555, 5'd0, st, rw, d, m);
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h12345678, 5'd0);
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL fl_accept_stall got=%b exp=1", bus.stall_o); end
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL fl_busy_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.Regwrite_o !== 1'b0) begin errors++; $display("FAIL fl_busy_rw got=%b exp=0", bus.Regwrite_o); end
        @(posedge clk); #1;
        idle_in();
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL fl_after_stall got=%b exp=0", bus.stall_o); end
        $display("op ST addr=00000080 flushed in BUSY");
        mem_op(1'b1, 1'b0, 32'h80, 32'h0, 5'd4, st, rw, d, m);
        checks++; if (d !== 32'hAAAA5555) begin errors++; $display("FAIL fl_ld_mdata got=%h exp=aaaa5555", d); end
        checks++; if (st !== 3'b011) begin errors++; $display("FAIL fl_ld_stall got=%b exp=011", st); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] st, rw; logic [31:0] d; logic m;
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h00000077, 5'd9);
        @(posedge clk); #1;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rm_busy_stall got=%b exp=1", bus.stall_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rm_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.ALU_result_o !== 32'h0) begin errors++; $display("FAIL rm_alu got=%h exp=0", bus.ALU_result_o); end
        checks++; if (bus.Reg_addr_o !== 5'h0) begin errors++; $display("FAIL rm_rd got=%h exp=0", bus.Reg_addr_o); end
        @(posedge clk); #1;
        idle_in();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rm_idle_stall got=%b exp=0", bus.stall_o); end
        $display("op ST addr=00000080 aborted by reset");
        @(posedge clk); #1;
        mem_op(1'b1, 1'b0, 32'h80, 32'h0, 5'd4, st, rw, d, m);
        checks++; if (d !== 32'hAAAA5555) begin errors++; $display("FAIL rm_ld_mdata got=%h exp=aaaa5555", d); end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        drive(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        checks++; if (bus.misalign_o !== 1'b1) begin errors++; $display("FAIL ma_flag got=%b exp=1", bus.misalign_o); end
        checks++; if (bus.Regwrite_o !== 1'b0) begin errors++; $display("FAIL ma_rw got=%b exp=0", bus.Regwrite_o); end
        checks++; if (bus.Mem_data_o !== 32'h0) begin errors++; $display("FAIL ma_mdata got=%h exp=0", bus.Mem_data_o); end
        $display("op LD addr=00000042 misalign=%b", bus.misalign_o);
        @(posedge clk); #1;
        idle_in();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_store_load();
        test_wrap();
        test_flush();
        test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
